lza_lzd_encode: RTL and testbench
=================================

// Module: lza_lzd_encode
// PURPOSE
//  Second half of the MAF leading-zero anticipator. Consumes the 56-bit indicator string F and the
//  GP_n/GN_n correction strings from the LZA precode stage (first half). Produces the normalisation
//  shift count, an all-zero flag and a one-bit correction flag for the normaliser.
//  Two-stage valid/ready pipeline; full throughput of one vector per cycle.
// PARAMETERS
//  LZA_W   56  indicator string width; bit LZA_W-1 is most significant
//  GRP_W   8   group width for first-level detection
//  N_GRP   7   LZA_W/GRP_W
//  CNT_W   6   shift-count width; must hold LZA_W
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      F/GP_n/GN_n/in_sign valid
//  in_ready   out  1      stage can accept this cycle
//  F          in   56     LZA indicator string from precode
//  GP_n       in   56     positive-path correction string
//  GN_n       in   56     negative-path correction string
//  in_sign    in   1      0: use GP_n, 1: use GN_n
//  out_valid  out  1      result valid
//  out_ready  in   1      normaliser accepts result
//  lz_cnt     out  6      leading zeros of F counted from bit 55 (0..56)
//  lz_zero    out  1      F was all zero
//  lz_corr    out  1      one-position correction required
// BEHAVIOUR
//  - Accept on in_valid & in_ready. Result reaches out_valid at the 2nd rising edge after accept:
//    accept edge k; S1 valid after k; S2/outputs valid after k+1.
//  - S1 (registered at accept), per group g = 0..6 covering bits [8g+7:8g]:
//    * nz[g]: the group is nonzero.
//    * pos[g]: 3-bit leading-one offset from the group MSB.
//    * cb[g]: bit of sel at that leading-one position, with sel = in_sign ? GN_n : GP_n.
//  - S2 (registered on S1 advance):
//    * G is the highest g with nz[g].
//    * lz_cnt = 8*(6-G) + pos[G]; lz_corr = cb[G]; lz_zero = 0.
//    * If no group is nonzero: lz_cnt = 56, lz_zero = 1, lz_corr = 0.
//  - Handshake:
//    * s2_adv = !s2_v | out_ready.
//    * s1_adv = s1_v & s2_adv.
//    * in_ready = !s1_v | s2_adv.
//    * in_ready is combinational from regs and out_ready; it does not depend on in_valid.
//  - While out_valid & !out_ready: lz_cnt/lz_zero/lz_corr/out_valid held stable.
//  - Both stages full and stalled: in_ready = 0; no data lost, duplicated or reordered.
//  - Simultaneous out-accept and in-accept with both stages full: all three move in one cycle.
//  - Reset (async, any cycle incl. mid-operation):
//    * s1_v, s2_v, out_valid = 0; lz_cnt = 0, lz_zero = 0, lz_corr = 0.
//    * In-flight vectors discarded.
//    * First accept possible on the first edge after rst deasserts.
//  - Data registers need no reset beyond the outputs; valid bits gate everything.
//  - Unused GP_n/GN_n bits (other than at the leading-one position) have no effect.
// STRUCTURE
//  - Shared package lza_pkg:
//    * constants LZA_W, GRP_W, N_GRP, CNT_W, LZA_ZERO_CNT (=56).
//    * typedef lza_str_t (logic [55:0]).
//  - Sub-module lzd_group8: 8-bit data + 8-bit sel in -> nz, pos[2:0], cb.
//    Purely combinational; instantiated N_GRP times ahead of S1.
//  - Top: S1/S2 registers, group priority select, handshake logic.
// TESTING
//  1. F=56'h80_0000_0000_0000, GP_n bit55=1, in_sign=0 -> lz_cnt=0, lz_zero=0, lz_corr=1, 2 cycles after accept.
//  2. F=56'h1, GN_n=0, in_sign=1 -> lz_cnt=55, lz_zero=0, lz_corr=0.
//  3. F=0, GP_n=all ones -> lz_cnt=56, lz_zero=1, lz_corr=0.
//  4. F=56'h0001_FF00_0000_00 (MSB bit 40):
//     GP_n bit40=1, sign=0 -> lz_cnt=15, lz_corr=1.
//     Same F, GN_n bit40=0, sign=1 -> lz_cnt=15, lz_corr=0.
//  5. Stream 4 vectors back-to-back with out_ready=0 for 3 cycles:
//     in_ready falls after 2 accepts; outputs held stable; 4 results emerge in order; no gaps once out_ready=1.
//  6. Both stages full, rst pulsed for 1 cycle -> out_valid=0 and in_ready=1 immediately; no stale result ever appears.

Source files
------------

// File: rtl/lza_lzd_encode_pkg.sv
// Shared constants and types for the LZA leading-zero detect/encode stage.
package lza_pkg;
  localparam int LZA_W = 56;
  localparam int GRP_W = 8;
  localparam int N_GRP = LZA_W / GRP_W;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LZA_ZERO_CNT = CNT_W'(LZA_W);

  typedef logic [LZA_W-1:0] lza_str_t;
endpackage

// File: rtl/lza_lzd_encode_group8.sv
// 8-bit leading-one detector: nonzero flag, offset of the leading one from the MSB,
// and the correction bit of sel at that same position.
module lzd_group8 (
  input  logic [7:0] data_i,
  input  logic [7:0] sel_i,
  output logic       nz_o,
  output logic [2:0] pos_o,
  output logic       cb_o
);

  always_comb begin
    nz_o  = |data_i;
    pos_o = 3'd0;
    cb_o  = 1'b0;
    // Scan upward so the highest set bit is the one that sticks.
    for (int i = 0; i < 8; i++) begin
      if (data_i[i]) begin
        pos_o = 3'(7 - i);
        cb_o  = sel_i[i];
      end
    end
  end

endmodule

// File: rtl/lza_lzd_encode.sv
// LZA second half: grouped leading-zero detection of F and correction-bit pick,
// in a two-stage valid/ready pipeline with full throughput.
module lza_lzd_encode
  import lza_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  lza_str_t         F,
  input  lza_str_t         GP_n,
  input  lza_str_t         GN_n,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] lz_cnt,
  output logic             lz_zero,
  output logic             lz_corr
);

  lza_str_t                sel_p0;
  logic [N_GRP-1:0]        nz_p0;
  logic [N_GRP-1:0][2:0]   pos_p0;
  logic [N_GRP-1:0]        cb_p0;

  logic                    vld_p1_q, vld_p1_d;
  logic [N_GRP-1:0]        nz_p1_q;
  logic [N_GRP-1:0][2:0]   pos_p1_q;
  logic [N_GRP-1:0]        cb_p1_q;

  logic                    vld_p2_q, vld_p2_d;
  logic [CNT_W-1:0]        cnt_p2_q, cnt_p2_d;
  logic                    zero_p2_q, zero_p2_d;
  logic                    corr_p2_q, corr_p2_d;

  logic [CNT_W-1:0]        cnt_p1;
  logic                    zero_p1;
  logic                    corr_p1;

  logic                    s2_adv, s1_adv, accept;

  assign s2_adv   = !vld_p2_q || out_ready;
  assign s1_adv   = vld_p1_q && s2_adv;
  assign in_ready = !vld_p1_q || s2_adv;
  assign accept   = in_valid && in_ready;

  // ---- P0: per-group detection ahead of the S1 register ----
  assign sel_p0 = in_sign ? GN_n : GP_n;

  for (genvar g = 0; g < N_GRP; g++) begin : g_grp
    lzd_group8 u_grp (
      .data_i (F[GRP_W*g +: GRP_W]),
      .sel_i  (sel_p0[GRP_W*g +: GRP_W]),
      .nz_o   (nz_p0[g]),
      .pos_o  (pos_p0[g]),
      .cb_o   (cb_p0[g])
    );
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      nz_p1_q  <= nz_p0;
      pos_p1_q <= pos_p0;
      cb_p1_q  <= cb_p0;
    end
  end

  // ---- P1: group priority select feeding the output register ----
  always_comb begin
    cnt_p1  = LZA_ZERO_CNT;
    zero_p1 = 1'b1;
    corr_p1 = 1'b0;
    for (int g = 0; g < N_GRP; g++) begin
      if (nz_p1_q[g]) begin
        cnt_p1  = CNT_W'(GRP_W * (N_GRP - 1 - g)) + CNT_W'(pos_p1_q[g]);
        zero_p1 = 1'b0;
        corr_p1 = cb_p1_q[g];
      end
    end
  end

  always_comb begin
    vld_p1_d  = accept ? 1'b1 : (s1_adv ? 1'b0 : vld_p1_q);
    vld_p2_d  = s1_adv ? 1'b1 : (out_ready ? 1'b0 : vld_p2_q);
    cnt_p2_d  = s1_adv ? cnt_p1  : cnt_p2_q;
    zero_p2_d = s1_adv ? zero_p1 : zero_p2_q;
    corr_p2_d = s1_adv ? corr_p1 : corr_p2_q;
  end

  // ---- P2: output register, held while the normaliser stalls ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      cnt_p2_q  <= '0;
      zero_p2_q <= 1'b0;
      corr_p2_q <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      cnt_p2_q  <= cnt_p2_d;
      zero_p2_q <= zero_p2_d;
      corr_p2_q <= corr_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign lz_cnt    = cnt_p2_q;
  assign lz_zero   = zero_p2_q;
  assign lz_corr   = corr_p2_q;

endmodule

// File: tb/tb_lza_lzd_encode.sv
// Self-checking bench for lza_lzd_encode: directed spec vectors, stall/back-pressure,
// randomized streaming against a bit-scan reference model, and mid-flight reset.
module tb_lza_lzd_encode;
  import lza_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  lza_str_t   f = '0, gp_n = '0, gn_n = '0;
  logic       in_sign = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] lz_cnt;
  logic       lz_zero, lz_corr;

  int nt = 0;
  int nf = 0;

  typedef struct packed {
    logic [5:0] cnt;
    logic       zero;
    logic       corr;
  } res_t;

  res_t sb[$];

  lza_lzd_encode dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .F         (f),
    .GP_n      (gp_n),
    .GN_n      (gn_n),
    .in_sign   (in_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lz_cnt    (lz_cnt),
    .lz_zero   (lz_zero),
    .lz_corr   (lz_corr)
  );

  always #5 clk = ~clk;

  // Reference: scan F from bit 55 downward for the first one.
  function automatic res_t model(input lza_str_t ff, input lza_str_t gp, input lza_str_t gn,
                                 input logic s);
    res_t e;
    e.cnt  = 6'd56;
    e.zero = 1'b1;
    e.corr = 1'b0;
    for (int i = 55; i >= 0; i--) begin
      if (ff[i]) begin
        e.cnt  = 6'(55 - i);
        e.zero = 1'b0;
        e.corr = s ? gn[i] : gp[i];
        break;
      end
    end
    return e;
  endfunction

  function automatic lza_str_t rnd56();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[55:0];
  endfunction

  function automatic lza_str_t rnd_f();
    int sh;
    lza_str_t t;
    sh = $urandom_range(0, 60);
    if (sh > 55) return '0;
    t = rnd56();
    t[55] = 1'b1;
    return t >> sh;
  endfunction

  task automatic set_vec(input lza_str_t ff, input lza_str_t gp, input lza_str_t gn,
                         input logic s);
    f = ff; gp_n = gp; gn_n = gn; in_sign = s;
  endtask

  function automatic res_t obs();
    res_t o;
    o.cnt = lz_cnt; o.zero = lz_zero; o.corr = lz_corr;
    return o;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    nt++; if (out_valid !== 1'b0) begin nf++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    nt++; if (lz_cnt !== 6'd0) begin nf++; $display("FAIL reset_lz_cnt got=%0d exp=0", lz_cnt); end
    nt++; if (lz_zero !== 1'b0) begin nf++; $display("FAIL reset_lz_zero got=%b exp=0", lz_zero); end
    nt++; if (lz_corr !== 1'b0) begin nf++; $display("FAIL reset_lz_corr got=%b exp=0", lz_corr); end
    nt++; if (in_ready !== 1'b1) begin nf++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    lza_str_t fv[5], gpv[5], gnv[5];
    logic     sv[5];
    res_t     ev[5];
    fv[0] = 56'h80_0000_0000_0000; gpv[0] = rnd56() | (56'h1 << 55); gnv[0] = rnd56(); sv[0] = 1'b0;
    ev[0] = '{cnt: 6'd0,  zero: 1'b0, corr: 1'b1};
    fv[1] = 56'h1; gpv[1] = rnd56(); gnv[1] = '0; sv[1] = 1'b1;
    ev[1] = '{cnt: 6'd55, zero: 1'b0, corr: 1'b0};
    fv[2] = '0; gpv[2] = '1; gnv[2] = rnd56(); sv[2] = 1'($urandom_range(0, 1));
    ev[2] = '{cnt: 6'd56, zero: 1'b1, corr: 1'b0};
    fv[3] = 56'h0001_FF00_0000_00; gpv[3] = rnd56() | (56'h1 << 40); gnv[3] = rnd56(); sv[3] = 1'b0;
    ev[3] = '{cnt: 6'd15, zero: 1'b0, corr: 1'b1};
    fv[4] = 56'h0001_FF00_0000_00; gpv[4] = rnd56(); gnv[4] = rnd56() & ~(56'h1 << 40); sv[4] = 1'b1;
    ev[4] = '{cnt: 6'd15, zero: 1'b0, corr: 1'b0};
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      set_vec(fv[v], gpv[v], gnv[v], sv[v]);
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      nt++; if (in_ready !== 1'b1) begin nf++; $display("FAIL dir%0d_in_ready got=%b exp=1", v, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      set_vec(rnd56(), rnd56(), rnd56(), 1'($urandom_range(0, 1)));
      nt++; if (out_valid !== 1'b0) begin nf++; $display("FAIL dir%0d_early_valid got=%b exp=0", v, out_valid); end
      @(negedge clk);
      nt++;
      if (out_valid !== 1'b1 || obs() !== ev[v]) begin
        nf++;
        $display("FAIL dir%0d_result got v=%b cnt=%0d z=%b c=%b exp v=1 cnt=%0d z=%b c=%b",
                 v, out_valid, lz_cnt, lz_zero, lz_corr, ev[v].cnt, ev[v].zero, ev[v].corr);
      end
    end
  endtask

  task automatic test_back_to_back();
    lza_str_t fv[4], gpv[4], gnv[4];
    logic     sv[4];
    int       sent = 0, popped = 0;
    logic     held_v = 1'b0;
    res_t     held = '0, e;
    @(negedge clk);
    sb.delete();
    for (int k = 0; k < 4; k++) begin
      fv[k] = rnd_f(); gpv[k] = rnd56(); gnv[k] = rnd56(); sv[k] = 1'($urandom_range(0, 1));
    end
    for (int cyc = 0; cyc < 30 && popped < 4; cyc++) begin
      if (cyc > 0) @(negedge clk);
      out_ready = (cyc >= 3);
      in_valid  = (sent < 4);
      if (sent < 4) set_vec(fv[sent], gpv[sent], gnv[sent], sv[sent]);
      #1;
      if (cyc == 2) begin
        nt++;
        if (in_ready !== 1'b0 || sent != 2) begin
          nf++; $display("FAIL b2b_stall got in_ready=%b accepts=%0d exp in_ready=0 accepts=2", in_ready, sent);
        end
      end
      if (held_v) begin
        nt++;
        if (out_valid !== 1'b1 || obs() !== held) begin
          nf++; $display("FAIL b2b_hold got v=%b res=%h exp v=1 res=%h", out_valid, obs(), held);
        end
      end
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        nt++;
        if (obs() !== e) begin nf++; $display("FAIL b2b_order%0d got=%h exp=%h", popped, obs(), e); end
        popped++;
      end else if (popped > 0 && popped < 4) begin
        nt++; nf++; $display("FAIL b2b_gap got out_valid=%b exp=1", out_valid);
      end
      held_v = out_valid && !out_ready;
      held   = obs();
      if (in_valid && in_ready) begin
        sb.push_back(model(fv[sent], gpv[sent], gnv[sent], sv[sent]));
        sent++;
      end
    end
    nt++; if (popped != 4) begin nf++; $display("FAIL b2b_count got=%0d exp=4", popped); end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic held_v = 1'b0;
    res_t held = '0, e;
    int   outs = 0;
    @(negedge clk);
    sb.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      set_vec(rnd_f(), rnd56(), rnd56(), 1'($urandom_range(0, 1)));
      #1;
      if (held_v) begin
        nt++;
        if (out_valid !== 1'b1 || obs() !== held) begin
          nf++; $display("FAIL rnd_hold got v=%b res=%h exp v=1 res=%h", out_valid, obs(), held);
        end
      end
      if (out_valid && out_ready) begin
        nt++;
        if (sb.size() == 0) begin
          nf++; $display("FAIL rnd_spurious got res=%h exp none", obs());
        end else begin
          e = sb.pop_front();
          if (obs() !== e) begin nf++; $display("FAIL rnd_result%0d got=%h exp=%h", outs, obs(), e); end
        end
        outs++;
      end
      held_v = out_valid && !out_ready;
      held   = obs();
      if (in_valid && in_ready) sb.push_back(model(f, gp_n, gn_n, in_sign));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int d = 0; d < 10 && sb.size() > 0; d++) begin
      @(negedge clk);
      if (out_valid) begin
        e = sb.pop_front();
        nt++;
        if (obs() !== e) begin nf++; $display("FAIL rnd_drain got=%h exp=%h", obs(), e); end
      end
    end
    nt++; if (sb.size() != 0) begin nf++; $display("FAIL rnd_leftover got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_reset_midflight();
    lza_str_t nf_v, ngp, ngn;
    logic     ns;
    res_t     e;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_vec(rnd_f(), rnd56(), rnd56(), 1'b0);
    @(negedge clk);
    set_vec(rnd_f(), rnd56(), rnd56(), 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    nt++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      nf++; $display("FAIL rstmid_full got v=%b rdy=%b exp v=1 rdy=0", out_valid, in_ready);
    end
    rst = 1'b1;
    #1;
    nt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || lz_cnt !== 6'd0) begin
      nf++; $display("FAIL rstmid_async got v=%b rdy=%b cnt=%0d exp v=0 rdy=1 cnt=0", out_valid, in_ready, lz_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    nf_v = rnd_f(); ngp = rnd56(); ngn = rnd56(); ns = 1'($urandom_range(0, 1));
    e = model(nf_v, ngp, ngn, ns);
    set_vec(nf_v, ngp, ngn, ns);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    nt++; if (out_valid !== 1'b0) begin nf++; $display("FAIL rstmid_stale got=%b exp=0", out_valid); end
    @(negedge clk);
    nt++;
    if (out_valid !== 1'b1 || obs() !== e) begin
      nf++; $display("FAIL rstmid_first got v=%b res=%h exp v=1 res=%h", out_valid, obs(), e);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      nt++; if (out_valid !== 1'b0) begin nf++; $display("FAIL rstmid_ghost%0d got=%b exp=0", k, out_valid); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule
